// File: rtl/afifo_frame_writer_pkg.sv
// Shared types for the async FIFO write-side frame admission controller.
package afifo_frame_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   // Flag positions inside the FIFO word {err, last, payload}.
   function automatic int err_bit(input int data_width);
      return data_width + 1;
   endfunction

   function automatic int last_bit(input int data_width);
      return data_width;
   endfunction

endpackage

// File: rtl/afifo_frame_writer_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
   import afifo_frame_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   // Count enabled events, holding at the maximum value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 16'd0;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/afifo_frame_writer.sv
// Frame admission in front of an async FIFO write port: a frame is admitted
// only if a worst-case frame fits at its first beat, otherwise it is dropped
// whole; oversize frames are cut at MAX_FRAME beats and flagged with err.
module afifo_frame_writer
   import afifo_frame_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 5,
   parameter int MAX_FRAME  = 16
) (
   input  logic                  wr_clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   input  logic                  s_last_i,
   output logic                  s_ready_o,
   input  logic [PTR_WIDTH:0]    wr_cnt_i,
   input  logic                  wr_full_i,
   output logic                  wr_en_o,
   output logic [DATA_WIDTH+1:0] wr_data_o,
   output logic [15:0]           frame_cnt_o,
   output logic [15:0]           drop_cnt_o,
   output logic [15:0]           trunc_cnt_o,
   output logic                  ovf_o
);

   localparam int IDX_W    = $clog2(MAX_FRAME + 1);
   localparam int FREE_W   = PTR_WIDTH + 2;
   localparam int ERR_BIT  = err_bit(DATA_WIDTH);
   localparam int LAST_BIT = last_bit(DATA_WIDTH);

   localparam logic [FREE_W-1:0] DEPTH     = FREE_W'(2 ** PTR_WIDTH);
   localparam logic [FREE_W-1:0] NEED_FREE = FREE_W'(MAX_FRAME);
   localparam logic [IDX_W-1:0]  TRUNC_IDX = IDX_W'(MAX_FRAME - 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [FREE_W-1:0] free;
   logic              accept;
   logic              write, wr_last, wr_err;
   logic              inc_frame, inc_drop, inc_trunc;

   assign s_ready_o = (state == PASS) ? ~wr_full_i : 1'b1;
   assign accept    = s_valid_i & s_ready_o;

   // The beat registered last cycle is not yet reflected in wr_cnt_i.
   assign free = DEPTH - FREE_W'(wr_cnt_i) - FREE_W'(wr_en_o);

   // State and beat-index registers.
   always_ff @(posedge wr_clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Admission, forwarding and truncation decisions for the accepted beat.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      write     = 1'b0;
      wr_last   = 1'b0;
      wr_err    = 1'b0;
      inc_frame = 1'b0;
      inc_drop  = 1'b0;
      inc_trunc = 1'b0;
      if (accept) begin
         unique case (state)
            IDLE: begin
               if (free >= NEED_FREE) begin
                  write     = 1'b1;
                  wr_last   = s_last_i;
                  inc_frame = 1'b1;
                  idx_nxt   = IDX_W'(1);
                  if (!s_last_i) state_nxt = PASS;
               end else begin
                  inc_drop = 1'b1;
                  if (!s_last_i) state_nxt = DROP;
               end
            end
            PASS: begin
               write   = 1'b1;
               idx_nxt = idx + IDX_W'(1);
               if (s_last_i) begin
                  wr_last   = 1'b1;
                  state_nxt = IDLE;
               end else if (idx == TRUNC_IDX) begin
                  wr_last   = 1'b1;
                  wr_err    = 1'b1;
                  inc_trunc = 1'b1;
                  state_nxt = DROP;
               end
            end
            DROP: begin
               if (s_last_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FIFO write port: one-cycle pulse, data held between writes.
   always_ff @(posedge wr_clk_i) begin
      if (rst_i) begin
         wr_en_o   <= 1'b0;
         wr_data_o <= '0;
      end else begin
         wr_en_o <= write;
         if (write) begin
            wr_data_o[ERR_BIT]          <= wr_err;
            wr_data_o[LAST_BIT]         <= wr_last;
            wr_data_o[DATA_WIDTH-1:0]   <= s_data_i;
         end
      end
   end

   // Sticky flag for a write issued into a full FIFO.
   always_ff @(posedge wr_clk_i) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
      end else if (wr_en_o && wr_full_i) begin
         ovf_o <= 1'b1;
      end
   end

   sat_cnt16 u_frame_cnt (
      .clk   (wr_clk_i),
      .rst   (rst_i),
      .inc   (inc_frame),
      .count (frame_cnt_o)
   );

   sat_cnt16 u_drop_cnt (
      .clk   (wr_clk_i),
      .rst   (rst_i),
      .inc   (inc_drop),
      .count (drop_cnt_o)
   );

   sat_cnt16 u_trunc_cnt (
      .clk   (wr_clk_i),
      .rst   (rst_i),
      .inc   (inc_trunc),
      .count (trunc_cnt_o)
   );

endmodule

// File: tb/tb_afifo_frame_writer.sv
// Scoreboard bench for afifo_frame_writer: directed scenarios plus random
// frame traffic, checked against a frame-level reference model.
module tb_afifo_frame_writer;

   localparam int DW    = 8;
   localparam int PW    = 5;
   localparam int MAXF  = 16;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [DW-1:0] s_data_i = '0;
   logic          s_valid_i = 1'b0;
   logic          s_last_i = 1'b0;
   logic          s_ready_o;
   logic [PW:0]   wr_cnt_i = '0;
   logic          wr_full_i = 1'b0;
   logic          wr_en_o;
   logic [DW+1:0] wr_data_o;
   logic [15:0]   frame_cnt_o, drop_cnt_o, trunc_cnt_o;
   logic          ovf_o;

   afifo_frame_writer #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .MAX_FRAME(MAXF)) dut (
      .wr_clk_i    (clk),
      .rst_i       (rst_i),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_last_i    (s_last_i),
      .s_ready_o   (s_ready_o),
      .wr_cnt_i    (wr_cnt_i),
      .wr_full_i   (wr_full_i),
      .wr_en_o     (wr_en_o),
      .wr_data_o   (wr_data_o),
      .frame_cnt_o (frame_cnt_o),
      .drop_cnt_o  (drop_cnt_o),
      .trunc_cnt_o (trunc_cnt_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
   endtask

   // ---------------- reference model (frame level) ----------------
   // mode: 0 between frames, 1 forwarding, 2 discarding
   int          m_mode = 0;
   int          m_beats = 0;          // beats of the current frame already written
   bit          m_wrote_prev = 1'b0;  // a write is being presented this cycle
   bit          m_ovf = 1'b0;
   int unsigned m_frames = 0, m_drops = 0, m_truncs = 0;
   logic [DW+1:0] exp_q[$];

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
   endfunction

   task automatic model_step();
      bit accept;
      int free;
      bit wr_now;
      wr_now = m_wrote_prev;
      m_wrote_prev = 1'b0;
      if (rst_i) begin
         m_mode = 0; m_beats = 0; m_ovf = 1'b0;
         m_frames = 0; m_drops = 0; m_truncs = 0;
         return;
      end
      if (wr_now && wr_full_i) m_ovf = 1'b1;
      accept = s_valid_i && ((m_mode == 1) ? !wr_full_i : 1'b1);
      if (!accept) return;
      case (m_mode)
         0: begin
            free = DEPTH - int'(wr_cnt_i) - int'(wr_now);
            if (free >= MAXF) begin
               exp_q.push_back({1'b0, s_last_i, s_data_i});
               m_wrote_prev = 1'b1;
               m_frames = sat_inc(m_frames);
               m_beats = 1;
               if (!s_last_i) m_mode = 1;
            end else begin
               m_drops = sat_inc(m_drops);
               if (!s_last_i) m_mode = 2;
            end
         end
         1: begin
            m_wrote_prev = 1'b1;
            m_beats++;
            if (s_last_i) begin
               exp_q.push_back({1'b0, 1'b1, s_data_i});
               m_mode = 0;
            end else if (m_beats == MAXF) begin
               exp_q.push_back({1'b1, 1'b1, s_data_i});
               m_truncs = sat_inc(m_truncs);
               m_mode = 2;
            end else begin
               exp_q.push_back({1'b0, 1'b0, s_data_i});
            end
         end
         default: if (s_last_i) m_mode = 0;
      endcase
   endtask

   // One cycle of stimulus: check registered state, apply inputs, advance model.
   task automatic drive(input bit v, input logic [DW-1:0] d, input bit l,
                        input int cnt, input bit full, input bit r);
      @(negedge clk);
      chk("frame_cnt", 32'(frame_cnt_o), m_frames);
      chk("drop_cnt", 32'(drop_cnt_o), m_drops);
      chk("trunc_cnt", 32'(trunc_cnt_o), m_truncs);
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      s_valid_i = v; s_data_i = d; s_last_i = l;
      wr_cnt_i = (PW+1)'(cnt); wr_full_i = full; rst_i = r;
      #1;
      chk("s_ready", 32'(s_ready_o), (m_mode == 1) ? 32'(!full) : 32'd1);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   logic [DW+1:0] mon_hold = '0;

   always @(posedge clk) begin
      #1;
      if (rst_i) begin
         chk("rst_wr_en", 32'(wr_en_o), 0);
         chk("rst_wr_data", 32'(wr_data_o), 0);
         mon_hold = '0;
      end else if (wr_en_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(wr_data_o), 32'hDEAD);
         end else begin
            chk("wr_data", 32'(wr_data_o), 32'(exp_q.pop_front()));
         end
         mon_hold = wr_data_o;
      end else begin
         chk("wr_data_hold", 32'(wr_data_o), 32'(mon_hold));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lastp;
      drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);
      idle(2);

      // 4-beat frame into an empty FIFO
      for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), i == 3, 0, 1'b0, 1'b0);
      idle(2);

      // free 12 < 16: dropped whole
      for (int i = 0; i < 3; i++) drive(1'b1, 8'hB0 + 8'(i), i == 2, 20, 1'b0, 1'b0);
      idle(2);

      // wr_cnt 16 with a write in flight (free 15) drops, without it (free 16) admits
      drive(1'b1, 8'hC0, 1'b1, 0, 1'b0, 1'b0);
      drive(1'b1, 8'hD0, 1'b0, 16, 1'b0, 1'b0);
      drive(1'b1, 8'hD1, 1'b1, 16, 1'b0, 1'b0);
      idle(2);
      drive(1'b1, 8'hE0, 1'b0, 16, 1'b0, 1'b0);
      drive(1'b1, 8'hE1, 1'b1, 16, 1'b0, 1'b0);
      idle(2);

      // 20-beat frame: truncated at beat 16
      for (int i = 0; i < 20; i++) drive(1'b1, 8'h40 + 8'(i), i == 19, 0, 1'b0, 1'b0);
      idle(2);

      // back-to-back single-beat frames
      for (int i = 0; i < 10; i++) drive(1'b1, 8'h60 + 8'(i), 1'b1, 0, 1'b0, 1'b0);
      idle(2);

      // reset during beat 2 of a forwarded frame, then a normal frame
      drive(1'b1, 8'hF0, 1'b0, 0, 1'b0, 1'b0);
      drive(1'b1, 8'hF1, 1'b0, 0, 1'b0, 1'b1);
      idle(1);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h70 + 8'(i), i == 2, 0, 1'b0, 1'b0);
      idle(2);

      // write presented while full sets the sticky overflow flag
      drive(1'b1, 8'h99, 1'b1, 0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
      idle(2);

      // random traffic with varying frame lengths and occasional full
      for (int blk = 0; blk < 12; blk++) begin
         case (blk % 3)
            0: lastp = 4;
            1: lastp = 20;
            default: lastp = 50;
         endcase
         for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 99) < lastp,
                  int'($urandom_range(0, 31)), $urandom_range(0, 19) == 0, 1'b0);
         end
      end
      idle(4);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
